// File: rtl/dpe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dpe_pkg
// Purpose  : Shared types, default widths and sizing helper for the
//            approximate dot-product engine.
// Revision : 1.0
// ============================================================================
package dpe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_ACC_W = 24;
  localparam int DEF_ERR_W = 24;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int clog2_cnt(input int n);
    int w;
    w = 1;
    while ((1 << w) <= n) w = w + 1;
    return w;
  endfunction

endpackage : dpe_pkg
`default_nettype wire

// File: rtl/dpe_err_tracker.sv
`default_nettype none
// ============================================================================
// Module   : dpe_err_tracker
// Purpose  : Exact 8x8 product, |exact - approx| and saturating error sum.
// Revision : 1.0
// ============================================================================
module dpe_err_tracker #(
  parameter int ERR_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_valid,
  input  logic [7:0]       i_a,
  input  logic [7:0]       i_b,
  input  logic [15:0]      i_p,
  output logic [ERR_W-1:0] o_err_sum
);

  logic [15:0]      w_exact;
  logic [15:0]      w_diff;
  logic [ERR_W:0]   w_sum;
  logic [ERR_W-1:0] r_err;

  assign w_exact = {8'd0, i_a} * {8'd0, i_b};
  assign w_diff  = (w_exact >= i_p) ? (w_exact - i_p) : (i_p - w_exact);
  assign w_sum   = {1'b0, r_err} + (ERR_W+1)'(w_diff);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= '0;
    end else if (i_clear) begin
      r_err <= '0;
    end else if (i_valid) begin
      // Saturate rather than wrap so a large error never looks small.
      r_err <= w_sum[ERR_W] ? '1 : w_sum[ERR_W-1:0];
    end
  end

  assign o_err_sum = r_err;

endmodule : dpe_err_tracker
`default_nettype wire

// File: rtl/approx_dot_product_engine.sv
`default_nettype none
// ============================================================================
// Module   : approx_dot_product_engine
// Purpose  : Streaming 8-bit dot product around an external approximate
//            multiplier. Optional error tracking via MAC_ERR_TRACK_EN.
// Revision : 1.0
// ============================================================================
module approx_dot_product_engine
  import dpe_pkg::*;
#(
  parameter int VEC_LEN = 16,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int ERR_W   = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [7:0]       a_i,
  input  logic [7:0]       b_i,
  output logic [7:0]       mult_a_o,
  output logic [7:0]       mult_b_o,
  input  logic [15:0]      mult_p_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] acc_o,
  output logic [ERR_W-1:0] err_sum_o,
  output logic             overflow_o,
  output logic             busy_o
);

  localparam int CNT_W = clog2_cnt(VEC_LEN);
  localparam logic [CNT_W-1:0] c_vec_len   = CNT_W'(VEC_LEN);
  localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(VEC_LEN - 1);
  localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_v1;
  logic [7:0]       r_mult_a;
  logic [7:0]       r_mult_b;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic             r_out_valid;

  logic             w_ready;
  logic             w_accept;
  logic             w_start;
  logic [ACC_W:0]   w_sum;

  assign w_ready  = (r_state == RUN) && (r_cnt < c_vec_len);
  assign w_accept = in_valid_i && w_ready;
  assign w_start  = (r_state == IDLE) && start_i;
  assign w_sum    = {1'b0, r_acc} + (ACC_W+1)'(mult_p_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_v1        <= 1'b0;
      r_mult_a    <= '0;
      r_mult_b    <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_mult_a <= a_i;
        r_mult_b <= b_i;
        r_cnt    <= r_cnt + c_one;
      end
      // Product of the previous accept is on mult_p_i this cycle.
      if (r_v1) begin
        r_acc <= w_sum[ACC_W-1:0];
        if (w_sum[ACC_W]) r_ovf <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
          end
        end
        RUN: begin
          if (w_accept && (r_cnt == c_last_beat)) r_state <= DRAIN;
        end
        DRAIN: begin
          if (!r_v1) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (r_out_valid && out_ready_i) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = w_ready;
  assign mult_a_o    = r_mult_a;
  assign mult_b_o    = r_mult_b;
  assign acc_o       = r_acc;
  assign overflow_o  = r_ovf;
  assign out_valid_o = r_out_valid;
  assign busy_o      = (r_state != IDLE);

`ifdef MAC_ERR_TRACK_EN
  dpe_err_tracker #(
    .ERR_W (ERR_W)
  ) u_err_tracker (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_start),
    .i_valid   (r_v1),
    .i_a       (r_mult_a),
    .i_b       (r_mult_b),
    .i_p       (mult_p_i),
    .o_err_sum (err_sum_o)
  );
`else
  assign err_sum_o = '0;
`endif

endmodule : approx_dot_product_engine
`default_nettype wire

// File: tb/tb_approx_dot_product_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_approx_dot_product_engine
// Purpose  : Directed table-driven bench; a 24-bit and a 16-bit accumulator
//            instance share stimulus, each fed by its own multiplier model.
// Revision : 1.0
// ============================================================================
module tb_approx_dot_product_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        in_valid_i;
  logic [7:0]  a_i;
  logic [7:0]  b_i;
  logic        out_ready_i;
  logic        sub_mode;

  logic        in_ready_o,  in_ready16;
  logic [7:0]  mult_a_o,    mult_a16;
  logic [7:0]  mult_b_o,    mult_b16;
  logic [15:0] mult_p_i,    mult_p16;
  logic        out_valid_o, out_valid16;
  logic [23:0] acc_o;
  logic [15:0] acc16;
  logic [23:0] err_sum_o,   err16;
  logic        overflow_o,  overflow16;
  logic        busy_o,      busy16;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sub;
    logic [5:0]  pat;
    logic        start_mid;
    logic        start_exit;
    int          hold;
    logic [23:0] exp_acc;
    logic        exp_ovf;
    logic [15:0] exp_acc16;
    logic        exp_ovf16;
    logic [23:0] exp_err;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  function automatic logic [15:0] mdl_p(input logic [7:0] a, input logic [7:0] b,
                                        input logic sub);
    logic [15:0] e;
    e = {8'd0, a} * {8'd0, b};
    if (sub && e != 16'd0) e = e - 16'd1;
    return e;
  endfunction

  assign mult_p_i = mdl_p(mult_a_o, mult_b_o, sub_mode);
  assign mult_p16 = mdl_p(mult_a16, mult_b16, sub_mode);

  approx_dot_product_engine #(.VEC_LEN(4), .ACC_W(24), .ERR_W(24)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .a_i(a_i), .b_i(b_i), .mult_a_o(mult_a_o),
    .mult_b_o(mult_b_o), .mult_p_i(mult_p_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .acc_o(acc_o), .err_sum_o(err_sum_o),
    .overflow_o(overflow_o), .busy_o(busy_o)
  );

  approx_dot_product_engine #(.VEC_LEN(4), .ACC_W(16), .ERR_W(24)) dut16 (
    .clk(clk), .rst(rst), .start_i(start_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready16), .a_i(a_i), .b_i(b_i), .mult_a_o(mult_a16),
    .mult_b_o(mult_b16), .mult_p_i(mult_p16), .out_valid_o(out_valid16),
    .out_ready_i(out_ready_i), .acc_o(acc16), .err_sum_o(err16),
    .overflow_o(overflow16), .busy_o(busy16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          nacc;
    int          i;
    int          k;
    bit          rdy_ok;
    bit          stable_ok;
    logic [23:0] snap;
    logic [23:0] exp_err;
`ifdef MAC_ERR_TRACK_EN
    exp_err = v.exp_err;
`else
    exp_err = 24'd0;
`endif
    sub_mode = v.sub;
    rdy_ok   = 1'b1;
    // Offer a pair in IDLE together with start: it must not be taken.
    start_i    = 1'b1;
    in_valid_i = 1'b1;
    a_i        = v.a;
    b_i        = v.b;
    if (in_ready_o !== 1'b0) rdy_ok = 1'b0;
    tick();
    start_i = 1'b0;
    chk($sformatf("v%0d busy_after_start", idx), {31'd0, busy_o}, 32'd1);

    nacc = 0;
    i    = 0;
    while (nacc < 4 && i < 40) begin
      in_valid_i = (i < 6) ? v.pat[i] : 1'b1;
      start_i    = v.start_mid && (i == 1);
      a_i        = in_valid_i ? v.a : 8'hA5;
      b_i        = in_valid_i ? v.b : 8'h5A;
      if (in_ready_o !== 1'b1) rdy_ok = 1'b0;
      if (in_valid_i) nacc++;
      tick();
      i++;
    end
    in_valid_i = 1'b0;
    start_i    = 1'b0;
    chk($sformatf("v%0d in_ready_seq", idx), {31'd0, rdy_ok}, 32'd1);
    chk($sformatf("v%0d ready_low_after_last", idx), {31'd0, in_ready_o}, 32'd0);

    k = 1;
    while (out_valid_o !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk($sformatf("v%0d latency", idx), k, 32'd3);
    chk($sformatf("v%0d acc", idx), {8'd0, acc_o}, {8'd0, v.exp_acc});
    chk($sformatf("v%0d overflow", idx), {31'd0, overflow_o}, {31'd0, v.exp_ovf});
    chk($sformatf("v%0d err_sum", idx), {8'd0, err_sum_o}, {8'd0, exp_err});
    chk($sformatf("v%0d acc16", idx), {16'd0, acc16}, {16'd0, v.exp_acc16});
    chk($sformatf("v%0d overflow16", idx), {31'd0, overflow16}, {31'd0, v.exp_ovf16});

    if (v.hold > 0) begin
      stable_ok = 1'b1;
      snap      = acc_o;
      out_ready_i = 1'b0;
      for (int h = 0; h < v.hold; h++) begin
        tick();
        if (out_valid_o !== 1'b1 || acc_o !== snap) stable_ok = 1'b0;
      end
      chk($sformatf("v%0d hold_stable", idx), {31'd0, stable_ok}, 32'd1);
    end

    out_ready_i = 1'b1;
    start_i     = v.start_exit;
    tick();
    out_ready_i = 1'b0;
    start_i     = 1'b0;
    chk($sformatf("v%0d out_valid_cleared", idx), {31'd0, out_valid_o}, 32'd0);
    chk($sformatf("v%0d idle_after_handshake", idx), {31'd0, busy_o}, 32'd0);
    tick();
    chk($sformatf("v%0d still_idle", idx), {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    //         a      b     sub pat       smid sexit hold acc     ovf acc16   ovf16 err
    vecs[0] = '{8'd1,  8'd1,  1'b0, 6'b111111, 1'b0, 1'b0, 0,  24'd4,      1'b0, 16'd4,     1'b0, 24'd0};
    vecs[1] = '{8'd255,8'd255,1'b0, 6'b111111, 1'b0, 1'b0, 0,  24'd260100, 1'b0, 16'd63492, 1'b1, 24'd0};
    vecs[2] = '{8'd2,  8'd3,  1'b0, 6'b101101, 1'b0, 1'b0, 10, 24'd24,     1'b0, 16'd24,    1'b0, 24'd0};
    vecs[3] = '{8'd5,  8'd7,  1'b1, 6'b111111, 1'b0, 1'b0, 0,  24'd136,    1'b0, 16'd136,   1'b0, 24'd4};
    vecs[4] = '{8'd3,  8'd3,  1'b0, 6'b111111, 1'b1, 1'b1, 0,  24'd36,     1'b0, 16'd36,    1'b0, 24'd0};

    rst = 1'b1; start_i = 1'b0; in_valid_i = 1'b0; a_i = 8'd0; b_i = 8'd0;
    out_ready_i = 1'b0; sub_mode = 1'b0;
    tick();
    tick();
    chk("rst acc", {8'd0, acc_o}, 32'd0);
    chk("rst out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst busy", {31'd0, busy_o}, 32'd0);
    chk("rst in_ready", {31'd0, in_ready_o}, 32'd0);
    chk("rst overflow", {31'd0, overflow_o}, 32'd0);
    chk("rst mult_ab", {16'd0, mult_a_o, mult_b_o}, 32'd0);
    chk("rst err_sum", {8'd0, err_sum_o}, 32'd0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 4; v++) run_vec(vecs[v], v);

    // Reset in the middle of a run: two of four beats taken, then discarded.
    sub_mode = 1'b0;
    start_i  = 1'b1;
    tick();
    start_i    = 1'b0;
    in_valid_i = 1'b1;
    a_i        = 8'd4;
    b_i        = 8'd4;
    tick();
    tick();
    in_valid_i = 1'b0;
    rst        = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst busy", {31'd0, busy_o}, 32'd0);
    chk("midrst acc", {8'd0, acc_o}, 32'd0);
    chk("midrst in_ready", {31'd0, in_ready_o}, 32'd0);
    tick();
    chk("midrst acc_settled", {8'd0, acc_o}, 32'd0);

    run_vec(vecs[4], 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_approx_dot_product_engine
`default_nettype wire
